// File: rtl/seg7_scan_if.sv
// Bus between the datapath and the 4-digit seven-segment scan driver.
interface seg7_scan_if;
    logic [15:0] test_value;
    logic        hold;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        upd_pulse;

    modport master (
        output test_value, hold, blank_lz,
        input  seg, an, dp, upd_pulse
    );

    modport slave (
        input  test_value, hold, blank_lz,
        output seg, an, dp, upd_pulse
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit hex display driver with a blank guard before every digit
// and a shadow register that reloads only at the end of a full scan.
module seg7_scan_driver #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        rst,
    seg7_scan_if.slave  bus
);
    localparam int unsigned CNT_W   = 20;
    localparam int unsigned DIG_W   = 2;
    localparam int unsigned VAL_W   = 16;
    localparam logic [0:0]  S_BLANK = 1'b0;
    localparam logic [0:0]  S_DRIVE = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [DIG_W-1:0] dig_q,   dig_d;
    logic [VAL_W-1:0] shadow_q, shadow_d;
    logic             upd_q,   upd_d;

    logic [VAL_W-1:0] upper_c;
    logic             lz_off_c;
    logic [6:0]       seg_c;
    logic [3:0]       an_c;
    logic             dp_c;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_BLANK;
            cnt_q    <= '0;
            dig_q    <= '0;
            shadow_q <= '0;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            shadow_q <= shadow_d;
            upd_q    <= upd_d;
        end
    end

    // Slot sequencing; the shadow reloads only when digit 3 finishes driving.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        dig_d    = dig_q;
        shadow_d = shadow_q;
        upd_d    = 1'b0;
        case (state_q)
            S_BLANK: begin
                if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = S_DRIVE;
                    cnt_d   = '0;
                end
            end
            S_DRIVE: begin
                if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    dig_d   = dig_q + DIG_W'(1);
                    if (dig_q == DIG_W'(3) && !bus.hold) begin
                        shadow_d = bus.test_value;
                        upd_d    = (bus.test_value != shadow_q);
                    end
                end
            end
            default: begin
                state_d = S_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // Display decode: only registered state plus the live hold/blank_lz levels.
    always_comb begin
        seg_c    = 7'b1111111;
        an_c     = 4'b1111;
        dp_c     = 1'b1;
        upper_c  = shadow_q >> {dig_q, 2'b00};
        lz_off_c = bus.blank_lz && (dig_q != DIG_W'(0)) && (upper_c == '0);
        if (state_q == S_DRIVE) begin
            if (!lz_off_c) begin
                an_c  = ~(4'b0001 << dig_q);
                seg_c = hex_decode(upper_c[3:0]);
            end
            if (dig_q == DIG_W'(0) && bus.hold) begin
                dp_c = 1'b0;
            end
        end
    end

    assign bus.seg       = seg_c;
    assign bus.an        = an_c;
    assign bus.dp        = dp_c;
    assign bus.upd_pulse = upd_q;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, DRIVE-phase length per digit in clk cycles; legal range 1..2^20-1.
REQ-002 Parameter BLANK_CYCLES, default 500, all-digits-off guard length before each digit in clk cycles; legal range 1..2^16-1.
REQ-003 Port clk  input  1  rising-edge system clock, same clock as the datapath.
REQ-004 Port rst  input  1  reset, asynchronous assertion, active-low: one clock; reset is asynchronous and active-low.
REQ-005 Port test_value  input  16  memory-stage test value driven by the datapath, sampled synchronously.
REQ-006 Port hold  input  1  1 = freeze the displayed value.
REQ-007 Port blank_lz  input  1  1 = suppress leading zero digits.
REQ-008 Port seg  output  7  active-low segments; seg[0]=a .. seg[6]=g.
REQ-009 Port an  output  4  active-low digit enables; an[0] = rightmost digit = shadow[3:0].
REQ-010 Port dp  output  1  active-low decimal point, hold indicator.
REQ-011 Port upd_pulse  output  1  one-cycle pulse when the displayed value changes.

Function
REQ-012 FSM states: S_BLANK, S_DRIVE; cycle counter cnt; digit index dig 0..3; 16-bit shadow register.
REQ-013 S_BLANK lasts exactly BLANK_CYCLES cycles (cnt 0..BLANK_CYCLES-1), then S_DRIVE with cnt=0.
REQ-014 S_DRIVE lasts exactly REFRESH_DIV cycles, then S_BLANK with cnt=0 and dig=(dig+1) mod 4.
REQ-015 One digit slot = BLANK_CYCLES+REFRESH_DIV cycles; one full scan = 4 slots.
REQ-016 On the S_DRIVE->S_BLANK transition with dig=3 (wrap): shadow <= test_value if hold=0; shadow unchanged if hold=1.
REQ-017 upd_pulse = 1 in the cycle after a wrap load whose new shadow differs from the old shadow; 0 otherwise.
REQ-018 shadow is loaded only at wrap; test_value changes mid-scan never alter the current scan (no tearing).
REQ-019 In S_BLANK: an=4'b1111, seg=7'b1111111, dp=1.
REQ-020 In S_DRIVE: an has exactly bit dig low; seg = hex decode of shadow[4*dig+3:4*dig].
REQ-021 Decode (seg[6:0]): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-022 Leading-zero blanking: with blank_lz=1, digit dig>0 whose nibble and all higher nibbles are zero drives an=4'b1111 and seg=7'b1111111 for its DRIVE phase; digit 0 always shown; timing unchanged.
REQ-023 dp=0 only in S_DRIVE with dig=0 and hold=1; else dp=1.
REQ-024 seg, an, dp decode from registered state, shadow, and the live hold/blank_lz levels only; no combinational path from test_value to outputs.
REQ-025 hold and blank_lz take effect at any cycle; hold asserted in the wrap cycle blocks that load.

Reset
REQ-026 rst=0 asynchronously forces state=S_BLANK, cnt=0, dig=0, shadow=16'h0000, upd_pulse=0; hence an=4'b1111, seg=7'b1111111, dp=1.
REQ-027 Reset asserted mid-scan aborts the scan; after release the first load occurs at the end of the first full scan.
REQ-028 First rising clk edge after rst deasserts counts as cycle 0 of S_BLANK.

Verification (REFRESH_DIV=4, BLANK_CYCLES=1: slot=5, scan=20 cycles)
REQ-029 Reset release, test_value=16'h12AF -> cycles 0..19 show shadow 0000 (digits cycle an=1110,1101,1011,0111 in S_DRIVE); in cycle 20 upd_pulse=1; next scan shows F, A, 2, 1 on an[0..3] with seg 0001110, 0001000, 0100100, 1111001.
REQ-030 Hex coverage: sweep test_value 0x0123, 0x4567, 0x89AB, 0xCDEF one per scan -> every nibble matches REQ-021 table on its digit.
REQ-031 blank_lz=1, test_value=16'h0005 -> only an[0] ever low, seg=0010010; test_value=16'h0000 -> digit 0 shows 1000000, others dark.
REQ-032 hold=1 from mid-scan, test_value changed to 16'hBEEF -> shadow unchanged across next wraps, upd_pulse stays 0, dp=0 during digit-0 DRIVE; release hold -> BEEF shown after next wrap with one upd_pulse.
REQ-033 Same value reloaded at wrap -> upd_pulse stays 0; test_value toggled mid-scan -> displayed digits unchanged until wrap.
REQ-034 rst pulsed low during digit 2 DRIVE -> outputs go dark immediately, shadow=0000, scan restarts at dig=0 S_BLANK.
